// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the receiver FSM encoding and the oversampling divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int DATA_BITS = 8;

  // Rounded clock divider so that one tick lands every 1/OVERSAMPLE of a bit
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int den;
    den = baud * os;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO shared by the UART RX and TX paths.
// A push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a byte FIFO.
// The sample tick phase is realigned to every detected start edge.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        RX,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        overrun
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(DIV + 1);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  logic                 r_rx_m;
  logic                 r_rx_s;
  logic [TW-1:0]        r_tcnt;
  logic [SW-1:0]        r_scnt;
  logic [BW-1:0]        r_bcnt;
  logic [DATA_BITS-1:0] r_shift;
  rx_state_t            r_state;

  logic w_tick;
  logic w_start;
  logic w_bit_end;
  logic w_shift;
  logic w_stop_smp;
  logic w_push;
  logic w_full;
  logic w_empty;

  assign w_tick     = (r_tcnt == TW'(DIV - 1));
  assign w_start    = (r_state == IDLE) && !r_rx_s;
  assign w_bit_end  = w_tick && (r_scnt == SW'(OVERSAMPLE - 1));
  assign w_shift    = (r_state == DATA) && w_bit_end;
  assign w_stop_smp = (r_state == STOP) && w_bit_end;
  assign w_push     = w_stop_smp & r_rx_s;
  assign frame_err  = w_stop_smp & ~r_rx_s;
  // A full FIFO always has a valid head, so rx_ready alone decides the pop
  assign overrun    = w_push & w_full & ~rx_ready;
  assign rx_valid   = ~w_empty;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_rx_m <= RX;
      r_rx_s <= r_rx_m;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tcnt <= '0;
    end else if (w_start || w_tick) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_scnt  <= '0;
      r_bcnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            r_state <= START;
            r_scnt  <= '0;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_scnt == SW'(OVERSAMPLE / 2 - 1)) begin
              r_scnt  <= '0;
              r_bcnt  <= '0;
              r_state <= r_rx_s ? IDLE : DATA;
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (w_bit_end) begin
              r_scnt <= '0;
              if (r_bcnt == BW'(DATA_BITS - 1)) r_state <= STOP;
              else                              r_bcnt  <= r_bcnt + 1'b1;
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (w_bit_end) begin
              r_scnt  <= '0;
              r_state <= r_rx_s ? IDLE : WAIT_HIGH;
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        // Holds off a break condition until the line returns to idle
        WAIT_HIGH: begin
          if (r_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_shift) r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
  end

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (rx_ready),
    .o_data  (rx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames, popped bytes checked in order.
// Clock chosen so DIV=3 (48-cycle bits) to keep the run short.
module tb_uart_rx_fifo;

  localparam int CLK_HZ   = 5_600_000;
  localparam int BIT      = 48;   // 3 * 16
  localparam int STOP_LAT = 459;  // 2 sync + 1 enter START + 3*152 ticks

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] fifo_count;
  logic       frame_err;
  logic       overrun;

  int         n_checks = 0;
  int         n_fail = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  int         lat;
  int         f0;
  int         o0;
  logic [7:0] exp_q[$];
  logic [7:0] part;

  uart_rx_fifo #(
    .CLK_HZ(CLK_HZ), .BAUD(115200), .OVERSAMPLE(16), .FIFO_DEPTH(16)
  ) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX         (RX),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b);
    RX = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      wait_cyc(BIT);
    end
    RX = stop_b;
    wait_cyc(BIT);
  endtask

  task automatic drain(input int n);
    rx_ready = 1'b1;
    wait_cyc(n + 2);
    rx_ready = 1'b0;
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_count_zero", 32'(fifo_count), 32'd0);
  endtask

  // Monitor: every accepted head byte is compared against the scoreboard
  always @(negedge CLK) begin
    if (RST) begin
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got 0x%0h with no byte expected", rx_data);
        end else begin
          check("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    wait_cyc(3);
    @(negedge CLK);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    wait_cyc(5);

    // Single byte and push latency
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        for (int c = 1; c <= 600; c++) begin
          @(posedge CLK);
          #1;
          if (rx_valid) begin
            lat = c;
            break;
          end
        end
      end
    join
    check("a5_latency", 32'(lat), 32'(STOP_LAT));
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_count", 32'(fifo_count), 32'd1);
    drain(1);

    // Back-to-back frames, then a count staircase while draining
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    check("b2b_count", 32'(fifo_count), 32'd3);
    rx_ready = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      @(negedge CLK);
      check("b2b_staircase", 32'(fifo_count), 32'(k));
    end
    @(posedge CLK);
    #1;
    rx_ready = 1'b0;
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    // Glitch shorter than half a bit
    f0 = n_ferr;
    RX = 1'b0;
    wait_cyc(20);
    RX = 1'b1;
    wait_cyc(3 * BIT);
    check("glitch_count", 32'(fifo_count), 32'd0);
    check("glitch_valid", 32'(rx_valid), 32'd0);
    check("glitch_ferr", 32'(n_ferr), 32'(f0));

    // Framing error followed by a break, then a good byte
    f0 = n_ferr;
    send_byte(8'h55, 1'b0);
    wait_cyc(2 * BIT);
    RX = 1'b1;
    wait_cyc(BIT);
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    check("ferr_pulses", 32'(n_ferr), 32'(f0 + 1));
    check("ferr_count", 32'(fifo_count), 32'd1);
    check("ferr_data", 32'(rx_data), 32'h12);
    drain(1);

    // Fill, overrun, then simultaneous push and pop while full
    o0 = n_ovr;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    check("fill_count", 32'(fifo_count), 32'd16);
    send_byte(8'h99, 1'b1);
    check("ovr_pulses", 32'(n_ovr), 32'(o0 + 1));
    check("ovr_count", 32'(fifo_count), 32'd16);
    check("ovr_head", 32'(rx_data), 32'h00);
    exp_q.push_back(8'h99);
    fork
      send_byte(8'h99, 1'b1);
      begin
        wait_cyc(STOP_LAT - 1);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
      end
    join
    check("pp_ovr_pulses", 32'(n_ovr), 32'(o0 + 1));
    check("pp_count", 32'(fifo_count), 32'd16);
    check("pp_head", 32'(rx_data), 32'h01);
    check("pp_queue_len", 32'(exp_q.size()), 32'd16);
    drain(16);

    // Reset during data bit 4 with a byte already buffered
    send_byte(8'h5A, 1'b1);
    check("pre_rst_count", 32'(fifo_count), 32'd1);
    part = 8'hC3;
    RX = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      RX = part[i];
      wait_cyc(BIT);
    end
    RX = part[4];
    wait_cyc(BIT / 2);
    RST = 1'b0;
    @(negedge CLK);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_data", 32'(rx_data), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_ferr", 32'(frame_err), 32'd0);
    check("mid_rst_ovr", 32'(overrun), 32'd0);
    @(posedge CLK);
    #1;
    RX = 1'b1;
    wait_cyc(2 * BIT);
    RST = 1'b1;
    wait_cyc(BIT);
    f0 = n_ferr;
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    check("post_rst_count", 32'(fifo_count), 32'd1);
    check("post_rst_data", 32'(rx_data), 32'h7E);
    check("post_rst_ferr", 32'(n_ferr), 32'(f0));
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front-end for the RS-232 link of the RISC-V system. It synchronises the raw `RX` pin, deserialises 8N1 frames using 16× oversampling, and buffers received bytes in a first-word-fall-through FIFO. It sits directly upstream of the Avalon master UART, which drains bytes through a valid/ready handshake.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 115200: line rate.
- `OVERSAMPLE`, 16: samples per bit; must be even and ≥ 8.
- `FIFO_DEPTH`, 16: byte entries; power of two, ≥ 2.

Ports (direction, width, meaning):
- `CLK` in 1: system clock.
- `RST` in 1: reset, asynchronous, active-low.
- `RX` in 1: raw serial input, idle high, asynchronous to `CLK`.
- `rx_data` out 8: FIFO head byte; valid when `rx_valid`=1.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: consumer accepts head this cycle.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `frame_err` out 1: one-cycle pulse, stop bit sampled low.
- `overrun` out 1: one-cycle pulse, completed byte dropped because FIFO full.

## Operation
- Synchroniser: two flops on `RX`, both reset to 1. All logic uses the synchronised value `rx_s`.
- Tick generator: `DIV = round(CLK_HZ/(BAUD*OVERSAMPLE))`, which is 27 at the defaults. A free-running counter emits a one-cycle `tick` every `DIV` clocks. The counter reloads to 0 when the FSM leaves IDLE, which aligns sampling to the start edge.
- Sample counter `scnt` counts ticks within a bit. Bit counter `bcnt` runs 0..7.
- FSM states IDLE, START, DATA, STOP, WAIT_HIGH:
  - IDLE: when `rx_s`=0, go to START and clear `scnt`.
  - START: at tick `OVERSAMPLE/2-1` (mid-bit), sample. If 0, go to DATA with `scnt`=0 and `bcnt`=0. If 1 (glitch), return to IDLE with no flags.
  - DATA: every `OVERSAMPLE` ticks, shift `rx_s` into the shift register LSB-first. After bit 7, go to STOP.
  - STOP: after `OVERSAMPLE` ticks, sample.
    - If 1: push the byte and go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a break condition from re-triggering frames.
- FIFO (FWFT):
  - `rx_valid` = count≠0; `rx_data` = head entry.
  - Pop when `rx_valid && rx_ready`. `rx_ready` while empty is ignored.
  - Push when full and no pop in the same cycle: byte dropped, `overrun` pulses, contents unchanged.
  - Push and pop in the same cycle, including when full: both succeed and the count is unchanged.
  - Read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
- Reset values: `rx_data`=0, `rx_valid`=0, `fifo_count`=0, `frame_err`=0, `overrun`=0, FSM=IDLE, all counters 0.
- Reset asserted mid-frame or with a non-empty FIFO clears everything. The partial frame is lost and no flags are raised.

## Timing
- Sync latency is 2 cycles from a `RX` edge to `rx_s`.
- The push occurs on the cycle of the stop-bit sample. `rx_valid` and `fifo_count` update on the next clock edge, giving 1 cycle of latency. `rx_data` is valid in the same cycle as `rx_valid`.
- A pop updates the head/`rx_data` and `fifo_count` on the next edge.
- `frame_err` and `overrun` are high for exactly one cycle, coincident with the stop-bit sample cycle.
- At the defaults, bit period = 27×16 = 432 cycles and a full frame takes about 4320 cycles. The stop sample falls about 4104 cycles after the start edge.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum `rx_state_t` (IDLE, START, DATA, STOP, WAIT_HIGH);
  - the `DATA_BITS`=8 constant;
  - the function that computes `DIV` from `CLK_HZ`, `BAUD` and `OVERSAMPLE`.
- Sub-module `sync_fifo` is parameterised by width and depth, with push/pop/full/empty/count ports. It is reused later by the TX path.
- The top of the block contains the synchroniser, tick generator, FSM and shift register.

## Test plan
- Single byte at defaults: send 0xA5 (8N1, 432-cycle bits) with `rx_ready`=0 → `rx_valid`=1 and `rx_data`=0xA5 one cycle after the stop sample; `fifo_count`=1.
- Back-to-back frames: send 0x00, 0xFF, 0x3C with no idle gap, then raise `rx_ready` → bytes popped in order 0x00, 0xFF, 0x3C; `fifo_count` goes 3→2→1→0 on successive edges.
- Glitch rejection: drive `RX` low for 100 cycles, then high → FSM returns to IDLE; no push and no `frame_err`.
- Framing error: send 0x55 with the stop bit low, held low for 2 bit times, then a valid 0x12 → one `frame_err` pulse; only 0x12 appears in the FIFO.
- Overrun and simultaneous push/pop:
  - Fill 16 bytes (0x00..0x0F) with `rx_ready`=0, then send 0x99 → one `overrun` pulse; `fifo_count`=16; head is still 0x00.
  - Resend 0x99 with `rx_ready`=1 on the push cycle → pop of 0x00 and push of 0x99 both occur; count stays 16; 0x99 is the tail.
- Reset mid-frame: assert `RST`=0 during DATA bit 4, release, then send 0x7E → all outputs go to 0 while reset is asserted; after release only 0x7E is received.
